pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; successor to the 4-bit ripple full-adder chain.
//  Operand is split into CHUNK-bit slices; one slice resolved per stage, carry registered between stages.
//  Valid/ready handshake on both sides; used as the arithmetic unit feeding the datapath/register file.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of CHUNK, >= CHUNK
//  CHUNK    4  bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (latency in cycles)
// PORTS
//  Clk        in   1      rising-edge clock
//  Reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operands A,B,sub,c_in valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  sub        in   1      1: A - B (+ c_in ignored, see below); 0: A + B + c_in
//  c_in       in   1      carry-in for add mode
//  out_valid  out  1      S and flags valid
//  out_ready  in   1      downstream accepts result
//  S          out  WIDTH  result, modulo 2^WIDTH
//  c_out      out  1      carry out of MSB (sub mode: 1 = no borrow)
//  ovf        out  1      signed overflow
//  zero       out  1      S == 0
// BEHAVIOUR
//  - Reset (Reset_n=0, async): all stage valid bits, out_valid, S, c_out, ovf, zero -> 0; partial sums/carries -> 0.
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - advance = !out_valid || out_ready; in_ready = advance (combinational). Whole pipe moves or holds together.
//  - On advance every stage register loads from its predecessor, stage 0 from the inputs; valid bit of stage 0 = in_valid.
//  - Stage k (0..STAGES-1) computes slice k: {c, S[k*CHUNK+:CHUNK]} = A_k + B'_k + carry_k.
//    B' = sub ? ~B : B; carry_0 = sub ? 1 : c_in; carry_k+1 = carry out of slice k (registered).
//    Unprocessed slices of A,B' and completed slices of S are carried forward in the stage registers.
//  - Latency: result of an operand accepted at edge n is presented (out_valid=1) after edge n+STAGES-1, i.e.
//    visible in the cycle after STAGES accepting edges with no stall. Throughput 1 op/cycle.
//  - STAGES=1: single registered adder, latency 1.
//  - c_out = carry out of slice STAGES-1. ovf = (A[MSB]==B'[MSB]) && (S[MSB]!=A[MSB]). zero = ~|S.
//  - Stall: while out_valid && !out_ready, S/c_out/ovf/zero and all internal state hold exactly; in_ready=0.
//  - Bubbles: invalid stages still advance; out_valid low when the last stage holds a bubble; S value then don't-care
//    but must not be 'x after reset.
//  - Simultaneous out accept and in accept in same cycle allowed (full pipe sustains 1/cycle).
//  - Order preserved; no op dropped or duplicated. Reset mid-operation discards all in-flight ops.
//  - Arithmetic modulo 2^WIDTH; no saturation.
// TESTING (defaults WIDTH=16, CHUNK=4, latency 4)
//  1. Reset_n low mid-stream with 3 ops in flight -> out_valid=0 and S=0 immediately; no stale result after release.
//  2. A=16'h00FF, B=16'h0001, add, c_in=0 -> S=16'h0100, c_out=0, ovf=0, zero=0, out_valid 4 cycles after accept.
//  3. A=16'h7FFF, B=16'h0001 add -> S=16'h8000, ovf=1; A=16'h0005, B=16'h0005 sub -> S=0, zero=1, c_out=1.
//  4. A=16'hFFFF, B=16'h0000, c_in=1 add -> S=16'h0000, c_out=1, zero=1 (carry ripples across all 4 stages).
//  5. Back-to-back 8 ops, out_ready low for cycles 5-7 -> in_ready low same cycles, outputs held, all 8 in order.
//  6. Random 10k ops, random in_valid/out_ready, also WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=4 -> match scoreboard A±B.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry registered between stages, valid/ready handshake with whole-pipe stall.
module pipelined_add_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;
    localparam int unsigned MSB    = WIDTH - 1;
    localparam int unsigned CW     = CHUNK + 1;

    // The pipe either moves as a whole or holds as a whole.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [CW-1:0]    slice;
        logic [WIDTH-1:0] s_nxt;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        // Stage 0 takes operands directly; B is inverted and carry forced to 1 for subtract.
        if (k == 0) begin : g_head
            assign a_src = A;
            assign b_src = sub ? ~B : B;
            assign s_src = '0;
            assign c_src = sub | c_in;
            assign v_src = in_valid;
        end else begin : g_link
            assign a_src = g_stage[k-1].a_q;
            assign b_src = g_stage[k-1].b_q;
            assign s_src = g_stage[k-1].s_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
        end

        assign slice = CW'(a_src[k*CHUNK +: CHUNK]) + CW'(b_src[k*CHUNK +: CHUNK]) + CW'(c_src);

        always_comb begin
            s_nxt                    = s_src;
            s_nxt[k*CHUNK +: CHUNK]  = slice[CHUNK-1:0];
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                a_q <= a_src;
                b_q <= b_src;
                s_q <= s_nxt;
                c_q <= slice[CHUNK];
                v_q <= v_src;
            end
        end
    end

    // Flags are formed from the final-stage inputs so they register alongside S.
    logic [WIDTH-1:0] s_fin;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
    logic             zero_q;

    assign s_fin = g_stage[LAST].s_nxt;
    assign a_msb = g_stage[LAST].a_src[MSB];
    assign b_msb = g_stage[LAST].b_src[MSB];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= (a_msb == b_msb) && (s_fin[MSB] != a_msb);
            zero_q <= ~|s_fin;
        end
    end

    assign S         = g_stage[LAST].s_q;
    assign c_out     = g_stage[LAST].c_q;
    assign out_valid = g_stage[LAST].v_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, CHUNK=4): directed cases,
// stall/hold, mid-stream reset and randomised handshake against a scoreboard.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] S;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    logic acc;
    logic ir_seen;

    pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    always #5 Clk = ~Clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sb, input logic ci);
        res_t        r;
        logic [15:0] bp;
        logic [16:0] t;
        bp  = sb ? ~b : b;
        t   = {1'b0, a} + {1'b0, bp} + 17'(sb ? 1'b1 : ci);
        r.s = t[15:0];
        r.c = t[16];
        r.o = (a[15] == bp[15]) && (r.s[15] != a[15]);
        r.z = (r.s == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at +1 after posedge, book transfers at negedge.
    task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic sb, input logic ci, input logic ordy, input res_t e);
        res_t e0;
        in_valid = iv; A = a; B = b; sub = sb; c_in = ci; out_ready = ordy;
        @(negedge Clk);
        ir_seen = in_ready;
        acc     = iv && in_ready;
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed S=%h expected no result", S);
            end
            if (q.size() != 0) begin
                e0 = q.pop_front();
                chk("result", 32'({S, c_out, ovf, zero}), 32'(e0));
            end
        end
        if (acc) q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, ordy, '0);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sb,
                        input logic ci, input res_t e);
        int n = 0;
        do begin
            cyc(1'b1, a, b, sb, ci, 1'b1, e);
            n++;
        end while (!acc && n < 100);
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int          lat;
        int          idx;
        int          cn;
        logic [15:0] s_hold;
        logic [15:0] ta;
        logic [15:0] tb;
        logic        tsb;
        logic        tci;
        logic        ordy;

        // Reset state
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("reset_outputs", 32'({out_valid, S, c_out, ovf, zero}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Latency and carry across a slice boundary
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0100, c: 1'b0, o: 1'b0, z: 1'b0});
        lat = 0;
        while (!out_valid && lat < 20) begin
            idle(1'b1);
            lat++;
        end
        chk("latency_edges_after_accept", 32'(lat), 32'd3);
        drain();

        // Overflow, zero on subtract, carry through all stages
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, c: 1'b0, o: 1'b1, z: 1'b0});
        send(16'h0005, 16'h0005, 1'b1, 1'b0, '{s: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});
        send(16'hFFFF, 16'h0000, 1'b0, 1'b1, '{s: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, '{s: 16'h7FFF, c: 1'b1, o: 1'b1, z: 1'b0});
        send(16'h0003, 16'h0005, 1'b1, 1'b0, '{s: 16'hFFFE, c: 1'b0, o: 1'b0, z: 1'b0});
        drain();

        // Back-to-back 8 ops with out_ready low on cycles 5-7
        idx = 0;
        cn  = 0;
        s_hold = '0;
        while (idx < 8 && cn < 50) begin
            cn++;
            ordy = !(cn >= 5 && cn <= 7);
            ta   = 16'(idx * 16'h1111);
            tb   = 16'(idx + 3);
            tsb  = idx[0];
            if (cn == 5) s_hold = S;
            cyc(1'b1, ta, tb, tsb, 1'b0, ordy, model(ta, tb, tsb, 1'b0));
            if (acc) idx++;
            if (cn >= 5 && cn <= 7) begin
                chk("stall_in_ready_low", 32'(ir_seen), 32'd0);
                chk("stall_out_valid_held", 32'(out_valid), 32'd1);
                chk("stall_s_held", 32'(S), 32'(s_hold));
            end
        end
        chk("burst_accept_cycles", 32'(cn), 32'd11);
        drain();

        // Asynchronous reset with one result presented and three in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0, model(16'h1234, 16'h1111, 1'b0, 1'b0));
        send(16'h2222, 16'h0001, 1'b1, 1'b0, model(16'h2222, 16'h0001, 1'b1, 1'b0));
        send(16'h0F0F, 16'h0F0F, 1'b0, 1'b1, model(16'h0F0F, 16'h0F0F, 1'b0, 1'b1));
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, model(16'hAAAA, 16'h5555, 1'b0, 1'b0));
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({out_valid, S, c_out, ovf, zero}), 32'd0);
        q.delete();
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("no_stale_after_reset", 32'(out_valid), 32'd0);

        // Randomised traffic with random valid/ready
        for (int i = 0; i < 6000; i++) begin
            ta  = (i % 17 == 0) ? 16'hFFFF : 16'($urandom);
            tb  = (i % 13 == 0) ? 16'h0000 : 16'($urandom);
            tsb = 1'($urandom);
            tci = 1'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), ta, tb, tsb, tci,
                1'($urandom_range(0, 3) != 0), model(ta, tb, tsb, tci));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
